// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Imported by pipeline_hazard_ctrl, its interface and the hazard_compare unit.
package pipeline_pkg;

    // Controller FSM states; the encoding is visible on ctrl_state.
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } ctrl_state_e;

    localparam int             REG_W               = 5;
    localparam logic [REG_W-1:0] XZR               = 5'd31;
    localparam int             DEFAULT_MEM_TIMEOUT = 255;

    // Saturating 32-bit increment for the performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        if (val == 32'hFFFF_FFFF) begin
            sat_inc32 = val;
        end else begin
            sat_inc32 = val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle between the pipeline datapath and the
// stall/flush controller. master = datapath side, slave = controller.
interface pipeline_hazard_ctrl_if;
    import pipeline_pkg::*;

    // Hazard / memory status from the datapath
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic             id_uses_rm;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rd;
    logic             mem_branch_taken;
    logic             mem_access;
    logic             dmem_ack;

    // Controls back to the datapath
    logic             dmem_req;
    logic             pc_wren;
    logic             wren_IF_ID;
    logic             wren_ID_EX;
    logic             wren_EX_MEM;
    logic             wren_MEM_WB;
    logic             flush_IF_ID;
    logic             flush_ID_EX;
    logic             flush_EX_MEM;
    logic             pc_src_branch;
    logic             mem_abort;
    logic [1:0]       ctrl_state;
    logic [31:0]      stall_cycles;
    logic [31:0]      flush_count;

    modport master (
        output id_rn, id_rm, id_uses_rm, ex_memread, ex_rd,
               mem_branch_taken, mem_access, dmem_ack,
        input  dmem_req, pc_wren, wren_IF_ID, wren_ID_EX, wren_EX_MEM,
               wren_MEM_WB, flush_IF_ID, flush_ID_EX, flush_EX_MEM,
               pc_src_branch, mem_abort, ctrl_state, stall_cycles, flush_count
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rm, ex_memread, ex_rd,
               mem_branch_taken, mem_access, dmem_ack,
        output dmem_req, pc_wren, wren_IF_ID, wren_ID_EX, wren_EX_MEM,
               wren_MEM_WB, flush_IF_ID, flush_ID_EX, flush_EX_MEM,
               pc_src_branch, mem_abort, ctrl_state, stall_cycles, flush_count
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_compare.sv
// hazard_compare: combinational load-use detector between ID_EX and IF_ID.
// Kept standalone so the forwarding unit can reuse the same compare.
module hazard_compare
    import pipeline_pkg::*;
(
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rm,
    output logic             load_use
);

    logic rn_match_s;
    logic rm_match_s;

    // Source-register match; XZR is never a real destination, so it never hazards.
    always_comb begin
        rn_match_s = (ex_rd == id_rn);
        rm_match_s = id_uses_rm & (ex_rd == id_rm);
        load_use   = ex_memread & (ex_rd != XZR) & (rn_match_s | rm_match_s);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Handles load-use bubbles, taken-branch squashes and data-memory wait/timeout.
// Optional feature macro: HAZARD_PERF_EN builds the saturating stall/flush
// performance counters; without it both counters read 0 and no flops exist.
// Outputs are combinational from state and inputs so each decision applies on
// the same clock edge. The wait counter counts cycles spent in MEM_WAIT; the
// abort fires on the MEM_TIMEOUT-th such cycle.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic                 clock,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hif
);

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    ctrl_state_e state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_abort_q, mem_abort_d;

    logic        load_use_s;
    logic [7:0]  wait_inc_s;
    logic [4:0]  wren_fsm_s;      // {pc, IF_ID, ID_EX, EX_MEM, MEM_WB}
    logic [2:0]  flush_fsm_s;     // {IF_ID, ID_EX, EX_MEM}
    logic        pc_src_fsm_s;
    logic        dmem_req_fsm_s;
    logic        branch_flush_s;
    logic [4:0]  wren_s;
    logic [2:0]  flush_s;
    logic        pc_src_s;
    logic        dmem_req_s;

    hazard_compare u_hazard_compare (
        .ex_memread (hif.ex_memread),
        .ex_rd      (hif.ex_rd),
        .id_rn      (hif.id_rn),
        .id_rm      (hif.id_rm),
        .id_uses_rm (hif.id_uses_rm),
        .load_use   (load_use_s)
    );

    // Next-state and control decode; memory wait outranks branch outranks load-use.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_abort_d    = mem_abort_q;
        wren_fsm_s     = 5'b11111;
        flush_fsm_s    = 3'b000;
        pc_src_fsm_s   = 1'b0;
        dmem_req_fsm_s = 1'b0;
        branch_flush_s = 1'b0;
        wait_inc_s     = wait_cnt_q + 8'd1;
        case (state_q)
            RUN: begin
                dmem_req_fsm_s = hif.mem_access;
                if (hif.mem_access & ~hif.dmem_ack) begin
                    wren_fsm_s = 5'b00000;
                    wait_cnt_d = 8'd0;
                    state_d    = MEM_WAIT;
                end else if (hif.mem_branch_taken) begin
                    flush_fsm_s    = 3'b111;
                    pc_src_fsm_s   = 1'b1;
                    branch_flush_s = 1'b1;
                    state_d        = FLUSH;
                end else if (load_use_s) begin
                    wren_fsm_s  = 5'b00111;
                    flush_fsm_s = 3'b010;
                    state_d     = LOAD_STALL;
                end else begin
                    state_d = RUN;
                end
            end
            LOAD_STALL: begin
                state_d = RUN;
            end
            MEM_WAIT: begin
                dmem_req_fsm_s = hif.mem_access;
                if (hif.dmem_ack) begin
                    wait_cnt_d = 8'd0;
                    state_d    = RUN;
                end else if (wait_inc_s == TIMEOUT_C) begin
                    mem_abort_d = 1'b1;
                    flush_fsm_s = 3'b001;
                    wait_cnt_d  = 8'd0;
                    state_d     = RUN;
                end else begin
                    wren_fsm_s = 5'b00000;
                    wait_cnt_d = wait_inc_s;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Reset overrides: freeze every register, bubble everything, drop the request.
    always_comb begin
        if (reset) begin
            wren_s     = 5'b00000;
            flush_s    = 3'b111;
            pc_src_s   = 1'b0;
            dmem_req_s = 1'b0;
        end else begin
            wren_s     = wren_fsm_s;
            flush_s    = flush_fsm_s;
            pc_src_s   = pc_src_fsm_s;
            dmem_req_s = dmem_req_fsm_s;
        end
    end

    // Controller state, wait counter and sticky abort flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            mem_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_abort_q <= mem_abort_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Counter updates: stalls whenever the PC is held, flushes per taken branch.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (~wren_s[4]) begin
            stall_cycles_d = sat_inc32(stall_cycles_q);
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (branch_flush_s) begin
            flush_count_d = sat_inc32(flush_count_q);
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign hif.stall_cycles = stall_cycles_q;
    assign hif.flush_count  = flush_count_q;
`else
    assign hif.stall_cycles = 32'd0;
    assign hif.flush_count  = 32'd0;
`endif

    assign hif.pc_wren       = wren_s[4];
    assign hif.wren_IF_ID    = wren_s[3];
    assign hif.wren_ID_EX    = wren_s[2];
    assign hif.wren_EX_MEM   = wren_s[1];
    assign hif.wren_MEM_WB   = wren_s[0];
    assign hif.flush_IF_ID   = flush_s[2];
    assign hif.flush_ID_EX   = flush_s[1];
    assign hif.flush_EX_MEM  = flush_s[0];
    assign hif.pc_src_branch = pc_src_s;
    assign hif.dmem_req      = dmem_req_s;
    assign hif.mem_abort     = mem_abort_q;
    assign hif.ctrl_state    = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=8). Stimulus pushes
// hand-written expected control vectors; a negedge monitor pops and compares.
// Expected vector layout: {pc,IF_ID,ID_EX,EX_MEM,MEM_WB wrens}_{IF_ID,ID_EX,
// EX_MEM flushes}_{pc_src}_{dmem_req}_{mem_abort}_{ctrl_state[1:0]}.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [12:0] ctl;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    localparam logic [12:0] V_RST  = 13'b00000_111_0_0_0_00;
    localparam logic [12:0] V_RUN  = 13'b11111_000_0_0_0_00;
    localparam logic [12:0] V_LU   = 13'b00111_010_0_0_0_00;
    localparam logic [12:0] V_LS   = 13'b11111_000_0_0_0_01;
    localparam logic [12:0] V_BR   = 13'b11111_111_1_0_0_00;
    localparam logic [12:0] V_FL   = 13'b11111_000_0_0_0_11;
    localparam logic [12:0] V_MW0  = 13'b00000_000_0_1_0_00;
    localparam logic [12:0] V_MWW  = 13'b00000_000_0_1_0_10;
    localparam logic [12:0] V_MWA  = 13'b11111_000_0_1_0_10;
    localparam logic [12:0] V_ZW   = 13'b11111_000_0_1_0_00;
    localparam logic [12:0] V_AB   = 13'b11111_001_0_1_0_10;
    localparam logic [12:0] V_RUNA = 13'b11111_000_0_0_1_00;
    localparam logic [12:0] V_MW0A = 13'b00000_000_0_1_1_00;
    localparam logic [12:0] V_MWWA = 13'b00000_000_0_1_1_10;

    // flags = {reset, id_uses_rm, ex_memread, mem_branch_taken, mem_access, dmem_ack}
    localparam logic [5:0] F_NONE = 6'b000000;

    logic clock;
    logic reset;
    exp_t exp_q[$];
    int   tests_run;
    int   tests_failed;
    int   step_idx;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;

    pipeline_hazard_ctrl_if hif();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .hif   (hif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic [4:0] rn, input logic [4:0] rm,
                         input logic [4:0] rd, input logic [5:0] flags);
        hif.id_rn            = rn;
        hif.id_rm            = rm;
        hif.ex_rd            = rd;
        hif.id_uses_rm       = flags[4];
        hif.ex_memread       = flags[3];
        hif.mem_branch_taken = flags[2];
        hif.mem_access       = flags[1];
        hif.dmem_ack         = flags[0];
    endtask

    task automatic push_exp(input logic [12:0] ctl);
        exp_t e;
        e.ctl   = ctl;
        e.stall = exp_stall;
        e.flush = exp_flush;
        exp_q.push_back(e);
    endtask

    // One cycle: drive inputs just after the edge and queue the expected response.
    task automatic step(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                        input logic [5:0] flags, input logic [12:0] ctl);
        @(posedge clock);
        #1;
        reset = flags[5];
        drive(rn, rm, rd, flags);
        push_exp(ctl);
`ifdef HAZARD_PERF_EN
        if (!flags[5]) begin
            if (!ctl[12]) exp_stall = exp_stall + 32'd1;
            if (ctl[4])   exp_flush = exp_flush + 32'd1;
        end
`endif
    endtask

    // Monitor: compare outputs mid-cycle whenever an expectation is pending.
    initial begin
        exp_t e;
        logic [12:0] act;
        step_idx = 0;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {hif.pc_wren, hif.wren_IF_ID, hif.wren_ID_EX, hif.wren_EX_MEM,
                       hif.wren_MEM_WB, hif.flush_IF_ID, hif.flush_ID_EX, hif.flush_EX_MEM,
                       hif.pc_src_branch, hif.dmem_req, hif.mem_abort, hif.ctrl_state};
                tests_run = tests_run + 3;
                if (act !== e.ctl) begin
                    tests_failed = tests_failed + 1;
                    $display("FAIL ctl step%0d: got %b want %b", step_idx, act, e.ctl);
                end
                if (hif.stall_cycles !== e.stall) begin
                    tests_failed = tests_failed + 1;
                    $display("FAIL stall_cycles step%0d: got %0d want %0d",
                             step_idx, hif.stall_cycles, e.stall);
                end
                if (hif.flush_count !== e.flush) begin
                    tests_failed = tests_failed + 1;
                    $display("FAIL flush_count step%0d: got %0d want %0d",
                             step_idx, hif.flush_count, e.flush);
                end
                step_idx = step_idx + 1;
            end
        end
    end

    // Watchdog against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_stall    = 32'd0;
        exp_flush    = 32'd0;
        reset        = 1'b1;
        drive(5'd0, 5'd0, 5'd0, F_NONE);

        step(5'd0, 5'd0, 5'd0, 6'b100000, V_RST);       // in reset
        step(5'd0, 5'd0, 5'd0, F_NONE,    V_RUN);       // idle
        // LDUR X2 then ADD X3,X2,X4 (Rn hazard)
        step(5'd2, 5'd4, 5'd2, 6'b011000, V_LU);
        step(5'd2, 5'd4, 5'd2, 6'b011000, V_LS);        // detection suppressed
        step(5'd0, 5'd0, 5'd0, F_NONE,    V_RUN);
        // Rm hazard, then Rm match with Rm unused
        step(5'd5, 5'd7, 5'd7, 6'b011000, V_LU);
        step(5'd0, 5'd0, 5'd0, F_NONE,    V_LS);
        step(5'd5, 5'd7, 5'd7, 6'b001000, V_RUN);
        // Load to X31 and reader of X31: no hazard
        step(5'd31, 5'd31, 5'd31, 6'b011000, V_RUN);
        step(5'd31, 5'd31, 5'd31, 6'b011000, V_RUN);
        // Register match but not a load
        step(5'd2, 5'd2, 5'd2, 6'b010000, V_RUN);
        // Taken branch, then FLUSH ignores a hazard
        step(5'd0, 5'd0, 5'd0, 6'b000100, V_BR);
        step(5'd2, 5'd2, 5'd2, 6'b011000, V_FL);
        step(5'd0, 5'd0, 5'd0, F_NONE,    V_RUN);
        // Zero-wait memory access
        step(5'd0, 5'd0, 5'd0, 6'b000011, V_ZW);
        // Ack after 4 stall cycles
        step(5'd0, 5'd0, 5'd0, 6'b000010, V_MW0);
        step(5'd0, 5'd0, 5'd0, 6'b000010, V_MWW);
        step(5'd0, 5'd0, 5'd0, 6'b000010, V_MWW);
        step(5'd0, 5'd0, 5'd0, 6'b000010, V_MWW);
        step(5'd0, 5'd0, 5'd0, 6'b000011, V_MWA);
        step(5'd0, 5'd0, 5'd0, F_NONE,    V_RUN);
        // Memory wait wins over a simultaneous branch
        step(5'd0, 5'd0, 5'd0, 6'b000110, V_MW0);
        step(5'd0, 5'd0, 5'd0, 6'b000011, V_MWA);
        // Timeout: RUN wait cycle, 7 MEM_WAIT stalls, abort on the 8th MEM_WAIT cycle
        step(5'd0, 5'd0, 5'd0, 6'b000010, V_MW0);
        for (int i = 0; i < 7; i++) begin
            step(5'd0, 5'd0, 5'd0, 6'b000010, V_MWW);
        end
        step(5'd0, 5'd0, 5'd0, 6'b000010, V_AB);
        step(5'd0, 5'd0, 5'd0, F_NONE,    V_RUNA);     // sticky abort
        step(5'd0, 5'd0, 5'd0, F_NONE,    V_RUNA);
        // Enter MEM_WAIT again, then reset asserted mid-cycle
        step(5'd0, 5'd0, 5'd0, 6'b000010, V_MW0A);
        step(5'd0, 5'd0, 5'd0, 6'b000010, V_MWWA);
        @(posedge clock);
        #1;
        drive(5'd0, 5'd0, 5'd0, 6'b000010);
        #1;
        reset     = 1'b1;
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        push_exp(V_RST);
        step(5'd0, 5'd0, 5'd0, 6'b000000, V_RUN);       // released, cleared state

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() != 0) @(posedge clock);
        end
        @(negedge clock);
        if (exp_q.size() != 0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
